gpu_rect_copy_controller: RTL and testbench
===========================================

GPU_RECT_COPY_CONTROLLER -- requirements
Module: gpu_rect_copy_controller

Interface
REQ-001 Parameter RECT_BASE, default 16'd0: word address of rect 0 in CPU data memory.
REQ-002 Parameter SCREEN_WIDTH, default 640: horizontal sweep length and X clamp limit.
REQ-003 Parameter SCREEN_HEIGHT, default 480: vertical sweep length and Y clamp limit.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock; all outputs change only on its rising edge, except on reset assertion.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 start  in  1  single-cycle request to copy one frame of 64 rects.
REQ-008 mem_addr  out  16  read address to CPU data memory; registered read, 1-cycle latency.
REQ-009 mem_dout  in  16  memory read data for the mem_addr of the previous cycle.
REQ-010 dout  out  16  processed rect word to the receiver.
REQ-011 state  out  3  phase: 0 WAIT_FOR_START, 1 READ_X, 2 READ_WIDTH, 3 READ_Y, 4 READ_HEIGHT, 5 READ_COLOR.
REQ-012 coord_generator  out  10  sweep coordinate or colour index.
REQ-013 rect_counter  out  4  rect index within the batch.
REQ-014 batch_counter  out  2  batch index; 4 batches of 16 rects.
REQ-015 batch_completed  out  1  0 = load/drain sub-phase, 1 = sweep sub-phase.
REQ-016 busy  out  1  high from the cycle after an accepted start until return to WAIT_FOR_START.

Function
REQ-017 In WAIT_FOR_START: busy=0, batch_completed=0, and all counters held at 0; start=1 SHALL begin batch 0, READ_X, on the next cycle.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 Phase order per batch SHALL be READ_X, READ_WIDTH, READ_Y, READ_HEIGHT, READ_COLOR.
REQ-020 After batch 3 READ_COLOR, state SHALL return to WAIT_FOR_START.
REQ-021 Each phase SHALL run three sub-phases: load, drain, sweep.
REQ-022 Load: 16 cycles, batch_completed=0, rect_counter 0..15, coord_generator=0.
REQ-023 Drain: 3 cycles, batch_completed=0, rect_counter held at 15, mem_addr held at rect 15's word.
REQ-024 Sweep: batch_completed=1 and rect_counter=0.
REQ-025 Sweep coord_generator SHALL run 0..SCREEN_WIDTH-1 in X/WIDTH, 0..SCREEN_HEIGHT-1 in Y/HEIGHT, and 0..15 in COLOR.
REQ-026 The last sweep cycle SHALL be followed directly by the next phase's first load cycle.
REQ-027 Rect record is 5 words: offset 0 x, 1 y, 2 width, 3 height, 4 color, each a signed 16-bit value.
REQ-028 mem_addr SHALL be RECT_BASE + (batch_counter*16 + rect_counter)*5 + field offset, and is issued in the same cycle as the rect_counter value.
REQ-029 dout SHALL carry the processed word for the rect_counter value presented exactly 3 cycles earlier: memory latency plus 2 internal register stages.
REQ-030 X phase: dout = clamp(x, 0, SCREEN_WIDTH); raw x is stored in a 16-entry internal table.
REQ-031 WIDTH phase: dout = clamp(x + width, 0, SCREEN_WIDTH), computed with a 17-bit signed sum.
REQ-032 Y phase: dout = clamp(y, 0, SCREEN_HEIGHT); raw y is stored in the internal table.
REQ-033 HEIGHT phase: dout = clamp(y + height, 0, SCREEN_HEIGHT), computed with a 17-bit signed sum.
REQ-034 COLOR phase: dout = the raw color word, unmodified.
REQ-035 During drain and sweep, dout SHALL hold rect 15's processed value, so repeated buffer writes are idempotent.
REQ-036 Frame length SHALL be 4 x (2x659 + 2x499 + 35) = 9404 cycles from the first READ_X cycle to WAIT_FOR_START.

Reset
REQ-037 reset asserted SHALL immediately force: state=0, busy=0, batch_completed=0, counters=0, mem_addr=RECT_BASE, dout=0, internal pipeline and table cleared.
REQ-038 Reset mid-frame SHALL abandon the frame; after release, no activity until a new start.

Verification
REQ-039 Rect 0 = {x=-5, y=10, w=20, h=500, color=16'h1234}; start -> dout sequence for rect 0 = 0, 15, 10, 480, 16'h1234, each 3 cycles after rect_counter=0 in that phase.
REQ-040 Start pulse -> busy=1 for exactly 9404 cycles; batch_counter steps 0..3; final cycle shows state=5, coord_generator=15, batch_counter=3.
REQ-041 Rect with x=700, w=10 -> X dout=640, WIDTH dout=640; rect with x=100, w=-200 -> WIDTH dout=0.
REQ-042 Start re-pulsed at cycle 100 of a frame -> no change in counters or phase; frame length stays 9404 cycles.
REQ-043 Reset asserted asynchronously in batch 2 READ_Y sweep -> all outputs take their reset values before the next clock edge; a new start runs a complete, correct frame.
REQ-044 Check that mem_addr for batch 1, rect 3, COLOR phase = RECT_BASE + 19*5 + 4 = RECT_BASE + 99.

Source files
------------

// File: rtl/gpu_rect_copy_controller_if.sv
// Bus between the rect copy controller and its environment: start request,
// CPU data memory read port, processed word output and phase/counter status.
interface gpu_rect_copy_controller_if;
  logic        start;
  logic [15:0] mem_addr;
  logic [15:0] mem_dout;
  logic [15:0] dout;
  logic [2:0]  state;
  logic [9:0]  coord_generator;
  logic [3:0]  rect_counter;
  logic [1:0]  batch_counter;
  logic        batch_completed;
  logic        busy;

  modport master (
    input  start, mem_dout,
    output mem_addr, dout, state, coord_generator, rect_counter,
           batch_counter, batch_completed, busy
  );

  modport slave (
    output start, mem_dout,
    input  mem_addr, dout, state, coord_generator, rect_counter,
           batch_counter, batch_completed, busy
  );
endinterface

// File: rtl/gpu_rect_copy_controller.sv
// Copies one frame of 64 rects (4 batches of 16) out of CPU data memory,
// clamping coordinates to the screen, while sweeping a coordinate per phase.
module gpu_rect_copy_controller #(
  parameter logic [15:0] RECT_BASE     = 16'd0,
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480
) (
  input logic clk,
  input logic reset,
  gpu_rect_copy_controller_if.master bus
);

  typedef enum logic [2:0] {
    WAIT_FOR_START = 3'd0,
    READ_X         = 3'd1,
    READ_WIDTH     = 3'd2,
    READ_Y         = 3'd3,
    READ_HEIGHT    = 3'd4,
    READ_COLOR     = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    SUB_LOAD  = 2'd0,
    SUB_DRAIN = 2'd1,
    SUB_SWEEP = 2'd2
  } sub_t;

  localparam logic [9:0]        X_LAST     = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]        Y_LAST     = 10'(SCREEN_HEIGHT - 1);
  localparam logic [9:0]        COLOR_LAST = 10'd15;
  localparam logic signed [16:0] X_LIMIT   = 17'(SCREEN_WIDTH);
  localparam logic signed [16:0] Y_LIMIT   = 17'(SCREEN_HEIGHT);

  // Sequencer state
  phase_t     phase_q, phase_d;
  sub_t       sub_q, sub_d;
  logic [3:0] rect_q, rect_d;
  logic [1:0] drain_q, drain_d;
  logic [9:0] coord_q, coord_d;
  logic [1:0] batch_q, batch_d;
  logic [9:0] sweep_last;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sweep_last = COLOR_LAST;
    case (phase_q)
      READ_X, READ_WIDTH:  sweep_last = X_LAST;
      READ_Y, READ_HEIGHT: sweep_last = Y_LAST;
      default:             sweep_last = COLOR_LAST;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    rect_d  = rect_q;
    drain_d = drain_q;
    coord_d = coord_q;
    batch_d = batch_q;
    if (phase_q == WAIT_FOR_START) begin
      sub_d   = SUB_LOAD;
      rect_d  = 4'd0;
      drain_d = 2'd0;
      coord_d = 10'd0;
      batch_d = 2'd0;
      if (bus.start) phase_d = READ_X;
    end else begin
      case (sub_q)
        SUB_LOAD: begin
          if (rect_q == 4'd15) begin
            sub_d   = SUB_DRAIN;
            drain_d = 2'd0;
          end else begin
            rect_d = rect_q + 4'd1;
          end
        end
        SUB_DRAIN: begin
          if (drain_q == 2'd2) begin
            sub_d   = SUB_SWEEP;
            rect_d  = 4'd0;
            coord_d = 10'd0;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
        SUB_SWEEP: begin
          if (coord_q == sweep_last) begin
            sub_d   = SUB_LOAD;
            rect_d  = 4'd0;
            coord_d = 10'd0;
            case (phase_q)
              READ_X:      phase_d = READ_WIDTH;
              READ_WIDTH:  phase_d = READ_Y;
              READ_Y:      phase_d = READ_HEIGHT;
              READ_HEIGHT: phase_d = READ_COLOR;
              default: begin
                if (batch_q == 2'd3) begin
                  phase_d = WAIT_FOR_START;
                  batch_d = 2'd0;
                end else begin
                  phase_d = READ_X;
                  batch_d = batch_q + 2'd1;
                end
              end
            endcase
          end else begin
            coord_d = coord_q + 10'd1;
          end
        end
        default: sub_d = SUB_LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= WAIT_FOR_START;
      sub_q   <= SUB_LOAD;
      rect_q  <= 4'd0;
      drain_q <= 2'd0;
      coord_q <= 10'd0;
      batch_q <= 2'd0;
    end else begin
      phase_q <= phase_d;
      sub_q   <= sub_d;
      rect_q  <= rect_d;
      drain_q <= drain_d;
      coord_q <= coord_d;
      batch_q <= batch_d;
    end
  end

  // Read address: record base of the current rect plus the field of this phase
  logic [15:0] rect_idx;
  logic [15:0] field_off;
  logic [15:0] mem_addr_c;

  always_comb begin
    field_off = 16'd0;
    case (phase_q)
      READ_Y:      field_off = 16'd1;
      READ_WIDTH:  field_off = 16'd2;
      READ_HEIGHT: field_off = 16'd3;
      READ_COLOR:  field_off = 16'd4;
      default:     field_off = 16'd0;
    endcase
    rect_idx   = {10'd0, batch_q, rect_q};
    mem_addr_c = RECT_BASE + (rect_idx << 2) + rect_idx + field_off;
  end

  // Data pipeline: address cycle -> memory -> capture -> processed output
  logic        fetch;
  logic        a_valid, b_valid;
  logic [3:0]  a_rect, b_rect;
  phase_t      a_phase, b_phase;
  logic [15:0] b_data;
  logic [15:0] coord_table [16];
  logic [15:0] dout_q;

  assign fetch = (phase_q != WAIT_FOR_START) && (sub_q != SUB_SWEEP);

  function automatic logic [15:0] clamp_to(input logic signed [16:0] v,
                                           input logic signed [16:0] hi);
    logic [15:0] r;
    if (v < 17'sd0)  r = 16'd0;
    else if (v > hi) r = hi[15:0];
    else             r = v[15:0];
    return r;
  endfunction

  logic signed [16:0] data_sext;
  logic signed [16:0] table_sext;
  logic signed [16:0] sum17;
  logic [15:0]        proc_word;

  always_comb begin
    data_sext  = {b_data[15], b_data};
    table_sext = {coord_table[b_rect][15], coord_table[b_rect]};
    sum17      = data_sext + table_sext;
    proc_word  = b_data;
    case (b_phase)
      READ_X:      proc_word = clamp_to(data_sext, X_LIMIT);
      READ_WIDTH:  proc_word = clamp_to(sum17, X_LIMIT);
      READ_Y:      proc_word = clamp_to(data_sext, Y_LIMIT);
      READ_HEIGHT: proc_word = clamp_to(sum17, Y_LIMIT);
      default:     proc_word = b_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_rect  <= 4'd0;
      a_phase <= WAIT_FOR_START;
      b_valid <= 1'b0;
      b_rect  <= 4'd0;
      b_phase <= WAIT_FOR_START;
      b_data  <= 16'd0;
      dout_q  <= 16'd0;
      // NOTE: the 16-entry table is small flop storage, so it is cleared on
      // reset to keep an abandoned frame from leaking into the next one.
      for (int i = 0; i < 16; i++) coord_table[i] <= 16'd0;
    end else begin
      a_valid <= fetch;
      a_rect  <= rect_q;
      a_phase <= phase_q;
      b_valid <= a_valid;
      b_rect  <= a_rect;
      b_phase <= a_phase;
      b_data  <= bus.mem_dout;
      // Sweep cycles never enter as valid, so dout keeps rect 15's word
      if (b_valid) begin
        dout_q <= proc_word;
        if (b_phase == READ_X || b_phase == READ_Y) coord_table[b_rect] <= b_data;
      end
    end
  end

  assign bus.mem_addr        = mem_addr_c;
  assign bus.dout            = dout_q;
  assign bus.state           = phase_q;
  assign bus.coord_generator = coord_q;
  assign bus.rect_counter    = rect_q;
  assign bus.batch_counter   = batch_q;
  assign bus.batch_completed = (sub_q == SUB_SWEEP);
  assign bus.busy            = (phase_q != WAIT_FOR_START);

endmodule

// File: tb/tb_gpu_rect_copy_controller.sv
// Randomized frames checked cycle by cycle against a schedule-level model of
// the rect copy controller, plus literal expectations that pin the model.
module tb_gpu_rect_copy_controller;

  localparam logic [15:0] TB_BASE   = 16'h0100;
  localparam int          FRAME_LEN = 9404;
  localparam int          MEM_WORDS = 320;

  typedef struct packed {
    logic [2:0]  st;
    logic [9:0]  coord;
    logic [3:0]  rect;
    logic [1:0]  batch;
    logic        bc;
    logic        busy;
    logic [15:0] addr;
    logic [15:0] dout;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpu_rect_copy_controller_if bus();

  gpu_rect_copy_controller #(
    .RECT_BASE(TB_BASE), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [15:0] mem [MEM_WORDS];

  // CPU data memory: registered read, one cycle latency
  always @(posedge clk) begin
    logic [15:0] rel;
    rel = bus.mem_addr - TB_BASE;
    if (rel < 16'(MEM_WORDS)) bus.mem_dout <= mem[rel];
    else                      bus.mem_dout <= 16'hBEEF;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] last_dout;

  obs_t        exp_a   [FRAME_LEN + 1];
  bit          fetch_a [FRAME_LEN + 1];
  logic [15:0] proc_a  [FRAME_LEN + 1];

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
      if (miscompares >= 40) finish_run();
    end
  endtask

  function automatic obs_t actual_obs();
    return {bus.state, bus.coord_generator, bus.rect_counter, bus.batch_counter,
            bus.batch_completed, bus.busy, bus.mem_addr, bus.dout};
  endfunction

  function automatic obs_t idle_obs(input logic [15:0] d);
    obs_t o;
    o = '0;
    o.addr = TB_BASE;
    o.dout = d;
    return o;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [15:0] clampi(input int v, input int hi);
    if (v < 0)  return 16'd0;
    if (v > hi) return 16'(hi);
    return 16'(v);
  endfunction

  // Processed word for phase p of global rect g, straight from the record
  function automatic logic [15:0] ref_word(input int p, input int g);
    int x, y, w, h;
    x = s16(mem[g*5 + 0]);
    y = s16(mem[g*5 + 1]);
    w = s16(mem[g*5 + 2]);
    h = s16(mem[g*5 + 3]);
    case (p)
      1:       return clampi(x, 640);
      2:       return clampi(x + w, 640);
      3:       return clampi(y, 480);
      4:       return clampi(y + h, 480);
      default: return mem[g*5 + 4];
    endcase
  endfunction

  function automatic int field_of(input int p);
    case (p)
      1: return 0;
      2: return 2;
      3: return 1;
      4: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int sweep_len(input int p);
    if (p <= 2) return 640;
    if (p <= 4) return 480;
    return 16;
  endfunction

  task automatic add_entry(inout int n, input int p, input int b, input int r,
                           input int c, input bit bc, input bit fetch);
    int g;
    g = b*16 + r;
    exp_a[n].st    = 3'(p);
    exp_a[n].coord = 10'(c);
    exp_a[n].rect  = 4'(r);
    exp_a[n].batch = 2'(b);
    exp_a[n].bc    = bc;
    exp_a[n].busy  = 1'b1;
    exp_a[n].addr  = TB_BASE + 16'(g*5 + field_of(p));
    exp_a[n].dout  = 16'd0;
    fetch_a[n]     = fetch;
    proc_a[n]      = fetch ? ref_word(p, g) : 16'd0;
    n++;
  endtask

  task automatic build_expect();
    int n;
    logic [15:0] d;
    n = 0;
    for (int b = 0; b < 4; b++)
      for (int p = 1; p <= 5; p++) begin
        for (int i = 0; i < 16; i++) add_entry(n, p, b, i, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)  add_entry(n, p, b, 15, 0, 1'b0, 1'b1);
        for (int c = 0; c < sweep_len(p); c++) add_entry(n, p, b, 0, c, 1'b1, 1'b0);
      end
    exp_a[FRAME_LEN] = idle_obs(16'd0);
    fetch_a[FRAME_LEN] = 1'b0;
    d = last_dout;
    for (int k = 0; k <= FRAME_LEN; k++) begin
      if (k >= 3 && fetch_a[k-3]) d = proc_a[k-3];
      exp_a[k].dout = d;
    end
  endtask

  function automatic logic [15:0] rand_word();
    int v;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    v = int'($urandom_range(0, 900)) - 150;
    return 16'(v);
  endfunction

  task automatic fill_mem(input bit pinned);
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = rand_word();
    if (pinned) begin
      mem[0]  = 16'hFFFB;  mem[1]  = 16'd10;  mem[2] = 16'd20;
      mem[3]  = 16'd500;   mem[4]  = 16'h1234;
      mem[5]  = 16'd700;   mem[7]  = 16'd10;
      mem[10] = 16'd100;   mem[12] = 16'hFF38;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), actual_obs(), idle_obs(last_dout));
    end
  endtask

  task automatic run_frame(input bit pins, input bit noisy, input int abort_at);
    int busy_cnt;
    obs_t o;
    busy_cnt = 0;
    build_expect();
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 0; k <= FRAME_LEN; k++) begin
      @(negedge clk);
      o = actual_obs();
      check($sformatf("cyc%0d", k), o, exp_a[k]);
      if (o.busy) busy_cnt++;
      if (pins) begin
        if (k == 3)    check("rect0_x",        o.dout, 16'd0);
        if (k == 4)    check("rect1_x_clamp",  o.dout, 16'd640);
        if (k == 662)  check("rect0_width",    o.dout, 16'd15);
        if (k == 663)  check("rect1_wid_clamp", o.dout, 16'd640);
        if (k == 664)  check("rect2_wid_neg",  o.dout, 16'd0);
        if (k == 1321) check("rect0_y",        o.dout, 16'd10);
        if (k == 1820) check("rect0_height",   o.dout, 16'd480);
        if (k == 2319) check("rect0_color",    o.dout, 16'h1234);
        if (k == 4670) check("b1r3_color_addr", o.addr, TB_BASE + 16'd99);
        if (k == 9403) check("final_cycle", {o.st, o.coord, o.batch}, {3'd5, 10'd15, 2'd3});
      end
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1 check("async_reset", actual_obs(), idle_obs(16'd0));
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        last_dout = 16'd0;
        return;
      end
      bus.start = noisy && (k < FRAME_LEN) && (k == 100 || $urandom_range(0, 7) == 0);
    end
    bus.start = 1'b0;
    last_dout = exp_a[FRAME_LEN].dout;
    check("busy_cycles", 64'(busy_cnt), 64'(FRAME_LEN));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    last_dout = 16'd0;
    @(negedge clk);
    check("reset_state", actual_obs(), idle_obs(16'd0));
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(3);

    fill_mem(1'b1);
    run_frame(1'b1, 1'b0, -1);
    idle_cycles(4);

    fill_mem(1'b0);
    run_frame(1'b0, 1'b1, -1);
    idle_cycles(2);

    // Abandoned inside batch 2 READ_Y sweep
    fill_mem(1'b0);
    run_frame(1'b0, 1'b0, 6100);
    idle_cycles(5);

    fill_mem(1'b1);
    run_frame(1'b1, 1'b0, -1);
    idle_cycles(3);

    finish_run();
  end

endmodule
